// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: PC sequencing, single-outstanding fetch handshake and a
// small {pc, inst} queue toward decode. Optional counters under IFETCH_STATS_EN.
module inst_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        inst_start,
   input  logic        inst_ready,
   output logic [31:0] i_addr,
   input  logic [31:0] inst,
   input  logic        inst_valid,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        exited
`ifdef IFETCH_STATS_EN
   ,
   output logic [31:0] stat_fetch,
   output logic [31:0] stat_stall
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] S_REQ   = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]       state;
   logic [31:0]      pc;
   logic [31:0]      req_pc;
   logic             discard;
   logic [CNT_W-1:0] count;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [31:0]      pc_mem   [DEPTH];
   logic [31:0]      inst_mem [DEPTH];

   logic full;
   logic push;
   logic pop;

   assign full       = (count == CNT_W'(DEPTH));
   // Reset also blocks issue: the memory side would accept a request we then forget.
   assign inst_start = (state == S_REQ) && !reset && !redirect && !exited && !full;
   assign i_addr     = (state == S_REQ) ? pc : req_pc;
   assign push       = (state == S_WAIT) && inst_valid && !discard && !redirect && !reset;
   assign pop        = out_valid && out_ready && !redirect && !reset;

   assign out_valid  = (count != '0);
   assign out_pc     = pc_mem[rd_ptr];
   assign out_inst   = inst_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         // A response still owed by the memory side must be swallowed after reset.
         if (((state == S_WAIT) || (state == S_DRAIN)) && !inst_valid)
            state <= S_DRAIN;
         else
            state <= S_REQ;
         pc      <= RESET_PC;
         count   <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         discard <= 1'b0;
      end else begin
         case (state)
            S_REQ: begin
               if (inst_start && inst_ready)
                  state <= S_WAIT;
            end
            S_WAIT: begin
               if (inst_valid) begin
                  state   <= S_REQ;
                  discard <= 1'b0;
               end else if (redirect) begin
                  discard <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (inst_valid)
                  state <= S_REQ;
            end
            default: state <= S_REQ;
         endcase

         if (redirect) begin
            pc     <= redirect_pc;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) begin
               pc     <= req_pc + 32'd4;
               wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop)
               rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
               count <= count + CNT_W'(1);
            else if (pop && !push)
               count <= count - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (inst_start && inst_ready)
         req_pc <= pc;
      if (push) begin
         pc_mem[wr_ptr]   <= req_pc;
         inst_mem[wr_ptr] <= inst;
      end
   end

`ifdef IFETCH_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_fetch <= '0;
         stat_stall <= '0;
      end else begin
         if (push)
            stat_fetch <= stat_fetch + 32'd1;
         if ((state == S_REQ) && full && !exited)
            stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

   // Issue is throttled by count, so a response can never land on a full queue.
   a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: transaction-level queue model plus a latency-programmable
// memory responder; directed scenarios with literal expectations.
module tb_inst_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_start;
   logic        inst_ready;
   logic [31:0] i_addr;
   logic [31:0] inst;
   logic        inst_valid;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        exited;
`ifdef IFETCH_STATS_EN
   logic [31:0] stat_fetch;
   logic [31:0] stat_stall;
`endif

   inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset),
      .inst_start(inst_start), .inst_ready(inst_ready), .i_addr(i_addr),
      .inst(inst), .inst_valid(inst_valid),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
      .redirect(redirect), .redirect_pc(redirect_pc), .exited(exited)
`ifdef IFETCH_STATS_EN
      , .stat_fetch(stat_fetch), .stat_stall(stat_stall)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model state: expected queue contents, next fetch PC and the single memory request.
   logic [63:0] mq[$];
   logic [31:0] exp_pc;
   bit          busy = 0;
   bit          drop = 0;
   int          cnt  = 0;
   logic [31:0] maddr = 32'h0;
   int          lat  = 0;
   bit          chk_en = 0;
   int          m_fetch = 0;
   int          m_stall = 0;
   logic [31:0] iss_log[$];
   logic [63:0] pop_log[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endfunction

   initial begin
      bit          v, exp_start, acc, do_push, do_pop, stall;
      logic [31:0] pc0;
      inst_valid = 1'b0;
      inst       = 32'h0;
      forever begin
         @(negedge clk);
         #2;
         v          = busy && (cnt == 0);
         inst_valid = v;
         inst       = v ? mem_word(maddr) : 32'h0;
         #1;
         exp_start = !reset && !busy && !redirect && !exited && (mq.size() < DEPTH);
         if (chk_en) begin
            chk("inst_start", inst_start, exp_start);
            if (exp_start) chk("i_addr", i_addr, exp_pc);
            chk("out_valid", out_valid, mq.size() != 0);
            if (mq.size() != 0) begin
               chk("out_pc", out_pc, mq[0][63:32]);
               chk("out_inst", out_inst, mq[0][31:0]);
            end
            chk("count", dut.count, mq.size());
`ifdef IFETCH_STATS_EN
            chk("stat_fetch", stat_fetch, m_fetch);
            chk("stat_stall", stat_stall, m_stall);
`endif
         end
         pc0     = exp_pc;
         acc     = exp_start && inst_ready;
         do_push = busy && v && !drop && !redirect && !reset;
         do_pop  = (mq.size() != 0) && out_ready && !redirect && !reset;
         stall   = !reset && !busy && (mq.size() == DEPTH) && !exited;
         if (busy && v) begin
            busy = 0;
            drop = 0;
         end else if (busy) begin
            cnt--;
         end
         if (reset) begin
            mq.delete();
            exp_pc  = RESET_PC;
            m_fetch = 0;
            m_stall = 0;
            if (busy) drop = 1;
         end else begin
            if (stall) m_stall++;
            if (do_pop) begin
               pop_log.push_back(mq[0]);
               void'(mq.pop_front());
            end
            if (do_push) begin
               mq.push_back({maddr, mem_word(maddr)});
               exp_pc = maddr + 32'd4;
               m_fetch++;
            end
            if (redirect) begin
               mq.delete();
               exp_pc = redirect_pc;
               if (busy) drop = 1;
            end
            if (acc) begin
               iss_log.push_back(pc0);
               busy  = 1;
               drop  = 0;
               maddr = pc0;
               cnt   = lat;
            end
         end
      end
   end

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic restart();
      exited    = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      chk("restart_idle", busy, 0);
      reset = 1'b1;
      @(negedge clk);
      reset  = 1'b0;
      exited = 1'b0;
      iss_log.delete();
      pop_log.delete();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_i_addr", i_addr, RESET_PC);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      reset       = 1'b1;
      inst_ready  = 1'b1;
      out_ready   = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      exited      = 1'b0;
      lat         = 0;
      run(3);
      reset  = 1'b0;
      chk_en = 1'b1;
      iss_log.delete();
      pop_log.delete();

      // Zero-latency memory, decode always ready
      run(10);
      chk("s1_n_iss", iss_log.size() >= 3, 1);
      chk("s1_iss0", iss_log[0], 32'h0);
      chk("s1_iss1", iss_log[1], 32'h4);
      chk("s1_iss2", iss_log[2], 32'h8);
      chk("s1_pop0", pop_log[0], 64'h0000_0000_DEAD_0000);
      chk("s1_pop1", pop_log[1], 64'h0000_0004_DEAD_0004);

      // Decode stalled until the queue fills
      restart();
      out_ready = 1'b0;
      run(20);
      chk("s2_start", inst_start, 0);
      chk("s2_count", dut.count, 4);
      chk("s2_n_iss", iss_log.size(), 4);
`ifdef IFETCH_STATS_EN
      chk("s2_stat_fetch", stat_fetch, 4);
`endif
      pop_log.delete();
      out_ready = 1'b1;
      run(12);
      chk("s2_pop0", pop_log[0][63:32], 32'h0);
      chk("s2_pop1", pop_log[1][63:32], 32'h4);
      chk("s2_pop2", pop_log[2][63:32], 32'h8);
      chk("s2_pop3", pop_log[3][63:32], 32'hC);
      chk("s2_iss4", iss_log[4], 32'h10);

      // Redirect while waiting for the 0x8 response
      restart();
      lat = 3;
      for (int i = 0; i < 60; i++) begin
         if (busy && maddr == 32'h8) break;
         @(negedge clk);
      end
      chk("s3_reach", busy && (maddr == 32'h8), 1);
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      iss_log.delete();
      pop_log.delete();
      @(negedge clk);
      redirect = 1'b0;
      run(20);
      chk("s3_iss0", iss_log[0], 32'h100);
      chk("s3_pop0", pop_log[0], 64'h0000_0100_DEAD_0100);

      // Redirect while idle in the request state
      lat = 0;
      for (int i = 0; i < 60; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      iss_log.delete();
      @(negedge clk);
      redirect = 1'b0;
      run(6);
      chk("s3b_iss0", iss_log[0], 32'h200);

      // Redirect in the same cycle the response arrives
      for (int i = 0; i < 60; i++) begin
         if (busy) break;
         @(negedge clk);
      end
      redirect    = 1'b1;
      redirect_pc = 32'h300;
      pop_log.delete();
      @(negedge clk);
      redirect = 1'b0;
      run(8);
      chk("s3c_pop0", pop_log[0][63:32], 32'h300);

      // Push and pop together at DEPTH-1, then wrap the pointers
      restart();
      lat       = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (busy && mq.size() == DEPTH - 1) break;
         @(negedge clk);
      end
      chk("s4_reach", busy && (mq.size() == DEPTH - 1), 1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("s4_count", dut.count, DEPTH - 1);
      for (int i = 0; i < 40; i++) begin
         out_ready = (i % 3 == 0);
         @(negedge clk);
      end
      chk("s4_pop0", pop_log[0][63:32], 32'h0);
      chk("s4_pop1", pop_log[1][63:32], 32'h4);
      chk("s4_pop2", pop_log[2][63:32], 32'h8);
      chk("s4_pop3", pop_log[3][63:32], 32'hC);
      chk("s4_pop4", pop_log[4][63:32], 32'h10);
      chk("s4_pop5", pop_log[5], 64'h0000_0014_DEAD_0014);

      // Reset with a fetch outstanding
      restart();
      lat = 4;
      for (int i = 0; i < 60; i++) begin
         if (busy && maddr == 32'h4) break;
         @(negedge clk);
      end
      chk("s5_reach", busy && (maddr == 32'h4), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      iss_log.delete();
      pop_log.delete();
      run(25);
      chk("s5_iss0", iss_log[0], RESET_PC);
      chk("s5_pop0", pop_log[0], 64'h0000_0000_DEAD_0000);

      // Reset landing on the response cycle
      lat = 0;
      for (int i = 0; i < 60; i++) begin
         if (busy) break;
         @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      iss_log.delete();
      run(8);
      chk("s5b_iss0", iss_log[0], RESET_PC);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
